// File: rtl/div_share_arb.sv
// div_share_arb
//   Shares one 32/16 unsigned start/done divider between NREQ requesters.
//   A round-robin arbiter accepts one request at a time. Requests whose
//   quotient cannot fit in 16 bits (including divide-by-zero) are answered
//   immediately with an error, without using the divider. All other requests
//   are launched with a one-cycle start pulse. The result goes back to the
//   owner over a valid/ready handshake, or an error is returned if the
//   divider does not answer within TMO cycles.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_dd, req_dv        packed dividends (32 bits each) / divisors (16 bits each)
//   rsp_valid/rsp_ready   per-requester response handshake (valid is one-hot)
//   rsp_qt, rsp_rm        shared quotient / remainder bus
//   rsp_err               overflow, divide-by-zero or timeout
//   div_start             one-cycle launch pulse to the divider
//   div_dd, div_dv        registered operands to the divider
//   div_done              divider result strobe, with div_qt / div_rm
module div_share_arb #(
  parameter int NREQ = 4,
  parameter int TMO  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_dd,
  input  logic [16*NREQ-1:0]   req_dv,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [15:0]          rsp_qt,
  output logic [15:0]          rsp_rm,
  output logic                 rsp_err,
  output logic                 div_start,
  output logic [31:0]          div_dd,
  output logic [15:0]          div_dv,
  input  logic                 div_done,
  input  logic [15:0]          div_qt,
  input  logic [15:0]          div_rm
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
  localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic [PW-1:0] gnt_reg, gnt_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   div_dd_reg, div_dd_next;
  logic [15:0]   div_dv_reg, div_dv_next;
  logic [15:0]   qt_reg, qt_next;
  logic [15:0]   rm_reg, rm_next;
  logic          err_reg, err_next;

  // Unpacked views of the packed operand buses.
  logic [31:0] dd_arr [NREQ];
  logic [15:0] dv_arr [NREQ];

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [31:0]   win_dd;
  logic [15:0]   win_dv;
  logic          screen_err;
  logic          accept_en;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign dd_arr[gi] = req_dd[32*gi +: 32];
      assign dv_arr[gi] = req_dv[16*gi +: 16];
    end
  endgenerate

  // Rotating priority: scan upward from ptr, wrapping at NREQ.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_reg} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign win_dd = dd_arr[win_idx];
  assign win_dv = dv_arr[win_idx];

  // The quotient fits in 16 bits exactly when dd < dv * 2^16, i.e. when the
  // upper dividend half is below the divisor. dv == 0 always fails this.
  assign screen_err = (win_dv == 16'h0000) || (win_dd[31:16] >= win_dv);

  // Held low while reset is asserted so that no accept is advertised then.
  assign accept_en = (state_reg == IDLE) && win_found && !reset;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign req_ready[gi] = accept_en && (win_idx == PW'(gi));
      assign rsp_valid[gi] = (state_reg == RESP) && (gnt_reg == PW'(gi));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    gnt_next    = gnt_reg;
    cnt_next    = cnt_reg;
    div_dd_next = div_dd_reg;
    div_dv_next = div_dv_reg;
    qt_next     = qt_reg;
    rm_next     = rm_reg;
    err_next    = err_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          gnt_next = win_idx;
          if (screen_err) begin
            qt_next    = 16'hFFFF;
            rm_next    = 16'hFFFF;
            err_next   = 1'b1;
            state_next = RESP;
          end else begin
            // Loaded on the accept edge so the operands are already on the
            // divider bus during the start pulse; screened requests never
            // disturb the divider operands.
            div_dd_next = win_dd;
            div_dv_next = win_dv;
            state_next  = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // A done in the last counted cycle still wins over the timeout.
        if (div_done) begin
          qt_next    = div_qt;
          rm_next    = div_rm;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          qt_next    = 16'hFFFF;
          rm_next    = 16'hFFFF;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready[gnt_reg]) begin
          ptr_next   = (gnt_reg == LAST_REQ) ? '0 : gnt_reg + PW'(1);
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      gnt_reg    <= '0;
      cnt_reg    <= '0;
      div_dd_reg <= '0;
      div_dv_reg <= '0;
      qt_reg     <= '0;
      rm_reg     <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      gnt_reg    <= gnt_next;
      cnt_reg    <= cnt_next;
      div_dd_reg <= div_dd_next;
      div_dv_reg <= div_dv_next;
      qt_reg     <= qt_next;
      rm_reg     <= rm_next;
      err_reg    <= err_next;
    end
  end

  assign div_start = (state_reg == ISSUE);
  assign div_dd    = div_dd_reg;
  assign div_dv    = div_dv_reg;
  assign rsp_qt    = qt_reg;
  assign rsp_rm    = rm_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_div_share_arb.sv
// Testbench for div_share_arb: table-driven vectors, hand-written corner
// sequences (fairness, timeout, stray done, reset in WAIT) and randomized
// traffic checked against a behavioural model of arbitration and division.
module tb_div_share_arb;
  localparam int NREQ = 4;
  localparam int TMO  = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*NREQ-1:0]  req_dd;
  logic [16*NREQ-1:0]  req_dv;
  logic [15:0]         rsp_qt, rsp_rm;
  logic                rsp_err;
  logic                div_start;
  logic [31:0]         div_dd;
  logic [15:0]         div_dv;
  logic                div_done, m_done, stray_done;
  logic [15:0]         m_qt, m_rm;

  div_share_arb #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_dd(req_dd), .req_dv(req_dv), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_qt(rsp_qt), .rsp_rm(rsp_rm), .rsp_err(rsp_err),
    .div_start(div_start), .div_dd(div_dd), .div_dv(div_dv),
    .div_done(div_done), .div_qt(m_qt), .div_rm(m_rm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: done arrives lat cycles after the start cycle.
  int lat = 18;
  bit model_off = 1'b0;
  int m_cnt;
  assign div_done = m_done | stray_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_qt   <= '0;
      m_rm   <= '0;
    end else begin
      m_done <= 1'b0;
      if (div_start && !model_off) begin
        m_cnt <= lat - 1;
        if (div_dv == 16'h0) begin
          m_qt <= 16'hFFFF;
          m_rm <= 16'hFFFF;
        end else begin
          m_qt <= 16'(div_dd / {16'h0, div_dv});
          m_rm <= 16'(div_dd % {16'h0, div_dv});
        end
      end else if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_cnt  <= 0;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, got, exp);
  endtask

  logic [31:0] op_dd [NREQ];
  logic [15:0] op_dv [NREQ];
  int model_ptr = 0;

  function automatic int pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_dd[32*i +: 32] = op_dd[i];
      req_dv[16*i +: 16] = op_dv[i];
    end
  endtask

  // One full transaction. Offsets are cycles relative to the accept cycle.
  task automatic txn(input logic [NREQ-1:0] vmask, input int rdelay, input string nm,
                     output int win, output int start_off, output int rsp_off,
                     output logic [15:0] qt, output logic [15:0] rm, output logic err);
    int t, n;
    bit stable, quiet;
    win = -1; start_off = -1; rsp_off = -1; qt = '0; rm = '0; err = 1'b0;
    @(negedge clk);
    drive_ops();
    req_valid = vmask;
    #1;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, "_accept"}, {31'b0, |req_ready}, 32'd1);
    if (req_ready == '0) begin
      req_valid = '0;
      return;
    end
    chk({nm, "_ready_onehot"}, $countones(req_ready), 32'd1);
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) win = i;
    t = cyc;
    @(negedge clk);
    // Operands are only guaranteed in the accept cycle; valid stays up to
    // show that no second accept happens while busy.
    for (int i = 0; i < NREQ; i++) begin
      req_dd[32*i +: 32] = $urandom;
      req_dv[16*i +: 16] = 16'($urandom);
    end
    quiet = 1'b1;
    n = 0;
    while (rsp_valid == '0 && n < 80) begin
      if (div_start && start_off < 0) start_off = cyc - t;
      if (req_ready != '0) quiet = 1'b0;
      @(negedge clk); n++;
    end
    chk({nm, "_rsp"}, {31'b0, |rsp_valid}, 32'd1);
    if (rsp_valid == '0) begin
      req_valid = '0;
      return;
    end
    chk({nm, "_rsp_owner"}, rsp_valid, NREQ'(1) << win);
    chk({nm, "_busy_quiet"}, {31'b0, quiet}, 32'd1);
    rsp_off = cyc - t;
    qt = rsp_qt; rm = rsp_rm; err = rsp_err;
    stable = 1'b1;
    if (rdelay > 0) rsp_ready = ~(NREQ'(1) << win);
    for (int d = 0; d < rdelay; d++) begin
      @(negedge clk);
      if (rsp_valid != (NREQ'(1) << win) || rsp_qt != qt || rsp_rm != rm ||
          rsp_err != err || req_ready != '0 || div_start) stable = 1'b0;
    end
    if (rdelay > 0) chk({nm, "_bp_stable"}, {31'b0, stable}, 32'd1);
    rsp_ready = NREQ'(1) << win;
    @(negedge clk);
    rsp_ready = '0;
    req_valid = '0;
    #1;
    chk({nm, "_rsp_drop"}, rsp_valid, '0);
    $display("txn %s req=%0d qt=%h rm=%h err=%0d start@%0d rsp@%0d",
             nm, win, qt, rm, err, start_off, rsp_off);
  endtask

  // Expected results derived from the arbitration rule and plain division.
  task automatic run_exp(input logic [NREQ-1:0] vmask, input int rdelay, input string nm);
    int w, g_w, g_s, g_r, e_s, e_r;
    logic [15:0] g_q, g_m, e_q, e_m;
    logic g_e, e_e;
    logic [31:0] dd;
    logic [15:0] dv;
    w = pick(vmask, model_ptr);
    dd = op_dd[w]; dv = op_dv[w];
    if (dv == 16'h0 || (dd / {16'h0, dv}) > 32'd65535) begin
      e_q = 16'hFFFF; e_m = 16'hFFFF; e_e = 1'b1; e_s = -1; e_r = 1;
    end else if (model_off) begin
      e_q = 16'hFFFF; e_m = 16'hFFFF; e_e = 1'b1; e_s = 1; e_r = TMO + 2;
    end else begin
      e_q = 16'(dd / {16'h0, dv}); e_m = 16'(dd % {16'h0, dv}); e_e = 1'b0;
      e_s = 1; e_r = lat + 2;
    end
    txn(vmask, rdelay, nm, g_w, g_s, g_r, g_q, g_m, g_e);
    chk({nm, "_winner"}, g_w, w);
    chk({nm, "_start"}, g_s, e_s);
    chk({nm, "_latency"}, g_r, e_r);
    chk({nm, "_qt"}, {16'h0, g_q}, {16'h0, e_q});
    chk({nm, "_rm"}, {16'h0, g_m}, {16'h0, e_m});
    chk({nm, "_err"}, {31'h0, g_e}, {31'h0, e_e});
    model_ptr = (w + 1) % NREQ;
  endtask

  typedef struct {
    int          r;
    logic [31:0] dd;
    logic [15:0] dv;
    int          rdelay;
    logic [15:0] qt;
    logic [15:0] rm;
    logic        err;
    int          soff;
    int          roff;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int w, s, r, n, ng;
    int grants [5];
    logic [15:0] q, m;
    logic e;
    logic [15:0] hi;

    vecs[0] = '{0, 32'd1000,       16'd7,      10, 16'd142,  16'd6,    1'b0,  1, 20};
    vecs[1] = '{2, 32'd5,          16'd0,      0,  16'hFFFF, 16'hFFFF, 1'b1, -1, 1};
    vecs[2] = '{1, 32'h0010_0000,  16'd16,     0,  16'hFFFF, 16'hFFFF, 1'b1, -1, 1};
    vecs[3] = '{3, 32'h000F_FFFF,  16'd16,     0,  16'hFFFF, 16'h000F, 1'b0,  1, 20};
    vecs[4] = '{0, 32'hFFFF_FFFF,  16'hFFFF,   0,  16'hFFFF, 16'hFFFF, 1'b1, -1, 1};
    vecs[5] = '{1, 32'hFFFE_FFFF,  16'hFFFF,   2,  16'hFFFF, 16'hFFFE, 1'b0,  1, 20};
    vecs[6] = '{2, 32'd12345,      16'd1,      0,  16'h3039, 16'h0000, 1'b0,  1, 20};
    vecs[7] = '{3, 32'd0,          16'd5,      0,  16'h0000, 16'h0000, 1'b0,  1, 20};

    reset = 1'b1;
    req_valid = '0; rsp_ready = '0; req_dd = '0; req_dv = '0; stray_done = 1'b0;
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_data", {rsp_qt, rsp_rm}, '0);
    chk("rst_flags", {30'h0, rsp_err, div_start}, '0);
    chk("rst_div_ops", {div_dd[15:0], div_dv}, '0);
    req_valid = '0;
    reset = 1'b0;

    // Fairness: all requesters busy, responses accepted immediately.
    for (int i = 0; i < NREQ; i++) begin
      op_dd[i] = 32'd100 * 32'(i + 1);
      op_dv[i] = 16'd3;
    end
    for (int k = 0; k < 5; k++) grants[k] = -1;
    @(negedge clk);
    drive_ops();
    req_valid = '1;
    rsp_ready = '1;
    ng = 0; n = 0;
    while (ng < 5 && n < 300) begin
      #1;
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants[ng] = i;
        ng++;
      end
      @(negedge clk); n++;
    end
    req_valid = '0;
    n = 0;
    while (rsp_valid == '0 && n < 60) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    rsp_ready = '0;
    chk("fair_count", ng, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("fair_grant%0d", k), grants[k], k % NREQ);
    $display("txn fairness grants %0d %0d %0d %0d %0d",
             grants[0], grants[1], grants[2], grants[3], grants[4]);
    model_ptr = 1;

    // Table vectors, one requester each.
    for (int v = 0; v < 8; v++) begin
      op_dd[vecs[v].r] = vecs[v].dd;
      op_dv[vecs[v].r] = vecs[v].dv;
      txn(NREQ'(1) << vecs[v].r, vecs[v].rdelay, $sformatf("vec%0d", v), w, s, r, q, m, e);
      chk($sformatf("vec%0d_winner", v), w, vecs[v].r);
      chk($sformatf("vec%0d_start", v), s, vecs[v].soff);
      chk($sformatf("vec%0d_latency", v), r, vecs[v].roff);
      chk($sformatf("vec%0d_qt", v), {16'h0, q}, {16'h0, vecs[v].qt});
      chk($sformatf("vec%0d_rm", v), {16'h0, m}, {16'h0, vecs[v].rm});
      chk($sformatf("vec%0d_err", v), {31'h0, e}, {31'h0, vecs[v].err});
      model_ptr = (vecs[v].r + 1) % NREQ;
    end

    // Timeout: divider never answers; a later stray done must be dropped.
    model_off = 1'b1;
    op_dd[1] = 32'd100; op_dv[1] = 16'd3;
    run_exp(4'b0010, 0, "timeout");
    model_off = 1'b0;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_rsp_valid", rsp_valid, '0);
    chk("stray_div_start", {31'h0, div_start}, '0);

    // Randomized traffic.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_dv[i] = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
        if ($urandom_range(0, 3) == 0) hi = 16'($urandom);
        else hi = 16'(32'($urandom) % (32'(op_dv[i]) + 32'd1));
        op_dd[i] = {hi, 16'($urandom)};
      end
      lat = $urandom_range(2, 25);
      run_exp(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3), $sformatf("rnd%0d", it));
    end
    lat = 18;

    // Reset while waiting for the divider.
    op_dd[2] = 32'd5000; op_dv[2] = 16'd9;
    @(negedge clk);
    drive_ops();
    req_valid = 4'b0100;
    #1;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    req_valid = '0;
    chk("rw_div_start", {31'h0, div_start}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rw_in_wait", rsp_valid, '0);
    reset = 1'b1;
    req_valid = '1;
    #1;
    chk("rw_req_ready", req_ready, '0);
    chk("rw_rsp", {rsp_valid, 11'h0, rsp_err, div_start, rsp_qt}, '0);
    chk("rw_rm", {16'h0, rsp_rm}, '0);
    chk("rw_div_dd", div_dd, '0);
    chk("rw_div_dv", {16'h0, div_dv}, '0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    op_dd[0] = 32'd77; op_dv[0] = 16'd10;
    op_dd[3] = 32'd9999; op_dv[3] = 16'd100;
    run_exp(4'b1001, 0, "post_rst_pri");
    op_dd[3] = 32'd65536; op_dv[3] = 16'd3;
    run_exp(4'b1000, 0, "post_rst_r3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
